// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer: FSM state encoding,
// datapath widths and the ECALL opcode.
package fetch_pkg;

  localparam int PC_W    = 64;
  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] ECALL_INSTR = 32'h00000073;

  typedef enum logic [1:0] {
    ST_ISSUE   = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_PRESENT = 2'd2,
    ST_HALT    = 2'd3
  } state_t;

endpackage

// File: rtl/fetch_sequencer_cla64.sv
// 64-bit carry-lookahead adder: 4-bit lookahead groups with group carries
// chained across the word.
module Cla64bit (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        cin,
  output logic [63:0] sum,
  output logic        cout
);

  logic [63:0] p;
  logic [63:0] g;
  logic [64:0] carry;
  logic        grp_g;
  logic        grp_p;

  assign p = a ^ b;
  assign g = a & b;

  always_comb begin
    carry    = '0;
    grp_g    = 1'b0;
    grp_p    = 1'b0;
    carry[0] = cin;
    for (int k = 0; k < 16; k++) begin
      grp_g = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      grp_p = &p[4*k +: 4];
      carry[4*k+1] = g[4*k] | (p[4*k] & carry[4*k]);
      carry[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & carry[4*k]);
      carry[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                   | (p[4*k+2] & p[4*k+1] & p[4*k] & carry[4*k]);
      carry[4*k+4] = grp_g | (grp_p & carry[4*k]);
    end
  end

  assign sum  = p ^ carry[63:0];
  assign cout = carry[64];

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, drives instruction memory, presents fetched
// words to decode over valid/ready. Optional macro: HALT_ON_ECALL_EN.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [PC_W-1:0] MAX_PC   = 64'd255
) (
  input  logic               clk,
  input  logic               reset,
  output logic [PC_W-1:0]    imem_pc,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic [INSTR_W-1:0] instr_out,
  output logic [PC_W-1:0]    pc_out,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_target,
  output logic               halt,
  output logic [31:0]        fetch_count
);

  // Handshake: a word transfers on any edge where instr_valid & instr_ready.
  // Once raised, instr_valid, instr_out and pc_out hold until that transfer,
  // a redirect, or reset.

  state_t              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [PC_W-1:0]     pc_inc;
  logic                inc_cout;
  logic [INSTR_W-1:0]  instr_d;
  logic [PC_W-1:0]     pc_out_d;
  logic                valid_d;
  logic [31:0]         count_d;
  logic                fire;
  logic                inc_ok;
  logic                redir_ok;
  logic                ecall_stop;

  Cla64bit u_pc_inc (
    .a    (pc_q),
    .b    (64'd1),
    .cin  (1'b0),
    .sum  (pc_inc),
    .cout (inc_cout)
  );

  assign imem_pc  = pc_q;
  assign halt     = (state_q == ST_HALT);
  assign fire     = (state_q == ST_PRESENT) && instr_valid && instr_ready;
  // Wrap of an all-ones pc counts as out of range.
  assign inc_ok   = !inc_cout && (pc_inc <= MAX_PC);
  assign redir_ok = (redirect_target <= MAX_PC);

`ifdef HALT_ON_ECALL_EN
  assign ecall_stop = fire && (instr_out == ECALL_INSTR);
`else
  assign ecall_stop = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_out;
    pc_out_d = pc_out;
    valid_d  = instr_valid;
    count_d  = fetch_count;
    unique case (state_q)
      ST_ISSUE, ST_CAPTURE: begin
        if (redirect_valid) begin
          valid_d = 1'b0;
          if (redir_ok) begin
            pc_d    = redirect_target;
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_HALT;
          end
        end else if (state_q == ST_ISSUE) begin
          state_d = ST_CAPTURE;
        end else begin
          instr_d  = imem_instr;
          pc_out_d = pc_q;
          valid_d  = 1'b1;
          state_d  = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (fire) begin
          valid_d = 1'b0;
          if (fetch_count != 32'hFFFF_FFFF) count_d = fetch_count + 32'd1;
        end
        // Redirect outranks pc + 1 but never suppresses a completing handshake.
        if (ecall_stop) begin
          state_d = ST_HALT;
        end else if (redirect_valid) begin
          valid_d = 1'b0;
          if (redir_ok) begin
            pc_d    = redirect_target;
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_HALT;
          end
        end else if (fire) begin
          if (inc_ok) begin
            pc_d    = pc_inc;
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_HALT;
          end
        end
      end
      ST_HALT: begin
        valid_d = 1'b0;
      end
      default: begin
        state_d = ST_HALT;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_ISSUE;
      pc_q        <= RESET_PC;
      instr_out   <= '0;
      pc_out      <= '0;
      instr_valid <= 1'b0;
      fetch_count <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_out   <= instr_d;
      pc_out      <= pc_out_d;
      instr_valid <= valid_d;
      fetch_count <= count_d;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: cycle table for the basic fetch stream,
// then hand sequences for stall, redirect, range halt and ECALL.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] imem_pc;
  logic [31:0] imem_instr;
  logic [31:0] instr_out;
  logic [63:0] pc_out;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_valid;
  logic [63:0] redirect_target;
  logic        halt;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;
  logic seen_pc3 = 1'b0;

  logic [31:0] mem [0:255];

  typedef struct {
    logic        ready;
    logic        exp_valid;
    logic [63:0] exp_pc_out;
    logic [31:0] exp_instr;
    logic [31:0] exp_count;
  } vec_t;

  vec_t vecs [9];

  fetch_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .imem_pc         (imem_pc),
    .imem_instr      (imem_instr),
    .instr_out       (instr_out),
    .pc_out          (pc_out),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .halt            (halt),
    .fetch_count     (fetch_count)
  );

  // Clock / reset / memory model
  always #5 clk = ~clk;

  always @(posedge clk) imem_instr <= mem[imem_pc[7:0]];

  always @(negedge clk) if (instr_valid && pc_out == 64'd3) seen_pc3 = 1'b1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver / checker tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!instr_valid && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (!instr_valid) begin
      errors++;
      $display("FAIL %s: instr_valid not seen within 20 cycles (got 0 expected 1)", name);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
    mem[0] = 32'h00A00093;
    mem[1] = 32'h00100113;
    mem[2] = 32'h002081B3;
    mem[4] = 32'h00000073;

    // cycle-by-cycle expectations after reset with instr_ready held high
    vecs[0] = '{1'b1, 1'b0, 64'd0, 32'h0,        32'd0};
    vecs[1] = '{1'b1, 1'b1, 64'd0, 32'h00A00093, 32'd0};
    vecs[2] = '{1'b1, 1'b0, 64'd0, 32'h00A00093, 32'd1};
    vecs[3] = '{1'b1, 1'b0, 64'd0, 32'h00A00093, 32'd1};
    vecs[4] = '{1'b1, 1'b1, 64'd1, 32'h00100113, 32'd1};
    vecs[5] = '{1'b1, 1'b0, 64'd1, 32'h00100113, 32'd2};
    vecs[6] = '{1'b1, 1'b0, 64'd1, 32'h00100113, 32'd2};
    vecs[7] = '{1'b1, 1'b1, 64'd2, 32'h002081B3, 32'd2};
    vecs[8] = '{1'b1, 1'b0, 64'd2, 32'h002081B3, 32'd3};

    instr_ready     = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    do_reset();
    chk("reset_valid", {63'd0, instr_valid}, 64'd0);
    chk("reset_halt", {63'd0, halt}, 64'd0);
    chk("reset_count", {32'd0, fetch_count}, 64'd0);
    chk("reset_pc_out", pc_out, 64'd0);
    chk("reset_instr", {32'd0, instr_out}, 64'd0);
    chk("reset_imem_pc", imem_pc, 64'd0);

    for (int i = 0; i < 9; i++) begin
      instr_ready = vecs[i].ready;
      step();
      chk($sformatf("vec%0d_valid", i), {63'd0, instr_valid}, {63'd0, vecs[i].exp_valid});
      chk($sformatf("vec%0d_pc_out", i), pc_out, vecs[i].exp_pc_out);
      chk($sformatf("vec%0d_instr", i), {32'd0, instr_out}, {32'd0, vecs[i].exp_instr});
      chk($sformatf("vec%0d_count", i), {32'd0, fetch_count}, {32'd0, vecs[i].exp_count});
    end

    // Redirect to 40 while pc 3 is in CAPTURE
    instr_ready = 1'b0;
    step();
    redirect_valid  = 1'b1;
    redirect_target = 64'd40;
    step();
    redirect_valid = 1'b0;
    chk("redir40_valid", {63'd0, instr_valid}, 64'd0);
    chk("redir40_imem_pc", imem_pc, 64'd40);
    wait_valid("redir40_wait");
    chk("redir40_pc_out", pc_out, 64'd40);
    chk("redir40_instr", {32'd0, instr_out}, {32'd0, mem[40]});
    chk("pc3_never_presented", {63'd0, seen_pc3}, 64'd0);

    // Stall five cycles in PRESENT
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("stall%0d_valid", i), {63'd0, instr_valid}, 64'd1);
      chk($sformatf("stall%0d_pc_out", i), pc_out, 64'd40);
      chk($sformatf("stall%0d_instr", i), {32'd0, instr_out}, {32'd0, mem[40]});
      chk($sformatf("stall%0d_imem_pc", i), imem_pc, 64'd40);
      chk($sformatf("stall%0d_count", i), {32'd0, fetch_count}, 64'd3);
    end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    chk("release_count", {32'd0, fetch_count}, 64'd4);
    chk("release_valid", {63'd0, instr_valid}, 64'd0);
    step();
    step();
    chk("next41_valid", {63'd0, instr_valid}, 64'd1);
    chk("next41_pc_out", pc_out, 64'd41);
    step();
    step();
    chk("one_handshake_count", {32'd0, fetch_count}, 64'd4);

    // Redirect and handshake in the same PRESENT cycle
    instr_ready     = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 64'd10;
    step();
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    chk("redir_hs_count", {32'd0, fetch_count}, 64'd5);
    chk("redir_hs_valid", {63'd0, instr_valid}, 64'd0);
    chk("redir_hs_imem_pc", imem_pc, 64'd10);
    wait_valid("redir10_wait");
    chk("redir10_pc_out", pc_out, 64'd10);
    chk("redir10_instr", {32'd0, instr_out}, {32'd0, mem[10]});

    // Out-of-range redirect from pc 5
    redirect_valid  = 1'b1;
    redirect_target = 64'd5;
    step();
    redirect_valid = 1'b0;
    wait_valid("redir5_wait");
    chk("redir5_pc_out", pc_out, 64'd5);
    redirect_valid  = 1'b1;
    redirect_target = 64'd300;
    step();
    chk("redir300_halt", {63'd0, halt}, 64'd1);
    chk("redir300_valid", {63'd0, instr_valid}, 64'd0);
    chk("redir300_imem_pc", imem_pc, 64'd5);
    redirect_target = 64'd7;
    step();
    step();
    step();
    redirect_valid = 1'b0;
    chk("halt_persist_halt", {63'd0, halt}, 64'd1);
    chk("halt_persist_imem_pc", imem_pc, 64'd5);
    chk("halt_persist_valid", {63'd0, instr_valid}, 64'd0);

    do_reset();
    chk("rst2_halt", {63'd0, halt}, 64'd0);
    chk("rst2_count", {32'd0, fetch_count}, 64'd0);
    chk("rst2_imem_pc", imem_pc, 64'd0);
    wait_valid("rst2_wait");
    chk("rst2_pc_out", pc_out, 64'd0);

    // Handshake at pc 255 runs off the end of memory
    redirect_valid  = 1'b1;
    redirect_target = 64'd255;
    step();
    redirect_valid = 1'b0;
    wait_valid("pc255_wait");
    chk("pc255_pc_out", pc_out, 64'd255);
    chk("pc255_instr", {32'd0, instr_out}, {32'd0, mem[255]});
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    chk("pc255_halt", {63'd0, halt}, 64'd1);
    chk("pc255_valid", {63'd0, instr_valid}, 64'd0);
    chk("pc255_count", {32'd0, fetch_count}, 64'd1);
    chk("pc255_imem_pc", imem_pc, 64'd255);
    step();
    step();
    chk("pc255_persist_halt", {63'd0, halt}, 64'd1);

    // ECALL at pc 4
    do_reset();
    instr_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_valid($sformatf("ecall_run%0d_wait", i));
      chk($sformatf("ecall_run%0d_pc_out", i), pc_out, 64'(i));
      step();
    end
    chk("ecall_count", {32'd0, fetch_count}, 64'd5);
`ifdef HALT_ON_ECALL_EN
    chk("ecall_halt", {63'd0, halt}, 64'd1);
    chk("ecall_valid", {63'd0, instr_valid}, 64'd0);
    step();
    step();
    chk("ecall_persist_halt", {63'd0, halt}, 64'd1);
`else
    chk("ecall_no_halt", {63'd0, halt}, 64'd0);
    wait_valid("ecall_next_wait");
    chk("ecall_next_pc_out", pc_out, 64'd5);
`endif
    instr_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
